// File: rtl/hash_update_arbiter.sv
// N-to-1 round-robin arbiter with a registered output for hash-table update words.
// Define HASH_UPD_ARB_STATS_EN to add per-channel grant counters (grant_cnt, stats_clr).
module hash_update_arbiter #(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 128,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch
`ifdef HASH_UPD_ARB_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [NUM_CH*32-1:0]     grant_cnt
`endif
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [CH_W-1:0]   win;
  logic              any;
  logic              accept;
  logic              load;

  // Rotated priority search; the modulo keeps odd NUM_CH off unused indices.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!any && in_valid[(int'(rr_ptr_q) + k) % NUM_CH]) begin
        any = 1'b1;
        win = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
      end
    end
  end

  // rst_n gates accept so no handshake is offered while held in reset.
  assign accept   = rst_n & (!out_valid_q | out_ready);
  assign load     = accept & any;
  assign in_ready = load ? (NUM_CH'(1) << win) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(win)*DATA_W +: DATA_W];
      out_ch_d    = win;
      rr_ptr_d    = (win == CH_W'(NUM_CH-1)) ? '0 : win + CH_W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

`ifdef HASH_UPD_ARB_STATS_EN
  logic [31:0] cnt_q [NUM_CH];

  // Clear beats a coincident grant; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (stats_clr) begin
          cnt_q[i] <= '0;
        end else if (load && win == CH_W'(i) && cnt_q[i] != '1) begin
          cnt_q[i] <= cnt_q[i] + 32'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign grant_cnt[g*32 +: 32] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_hash_update_arbiter.sv
// Bench for hash_update_arbiter: 4-channel instance with a scoreboard monitor,
// plus a 5-channel instance for the non-power-of-2 wrap.
module tb_hash_update_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   in_valid = '0;
  logic [3:0]   in_ready;
  logic [511:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [1:0]   out_ch;

  logic [4:0]   v5 = '0;
  logic [4:0]   r5;
  logic [639:0] d5 = '0;
  logic         ov5;
  logic         or5 = 1'b0;
  logic [127:0] od5;
  logic [2:0]   oc5;

`ifdef HASH_UPD_ARB_STATS_EN
  logic         sc4 = 1'b0;
  logic         sc5 = 1'b0;
  logic [127:0] gc4;
  logic [159:0] gc5;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hash_update_arbiter #(.NUM_CH(4), .DATA_W(128)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch)
`ifdef HASH_UPD_ARB_STATS_EN
    , .stats_clr(sc4), .grant_cnt(gc4)
`endif
  );

  hash_update_arbiter #(.NUM_CH(5), .DATA_W(128)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v5), .in_ready(r5), .in_data(d5),
    .out_valid(ov5), .out_ready(or5),
    .out_data(od5), .out_ch(oc5)
`ifdef HASH_UPD_ARB_STATS_EN
    , .stats_clr(sc5), .grant_cnt(gc5)
`endif
  );

  typedef struct packed {
    logic [1:0]   ch;
    logic [127:0] data;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [1:0] m_ptr = '0;
  logic       m_ov = 1'b0;
  int         m_w;
  int         m_j;
  logic [3:0] m_rdy;

  always @(negedge rst_n) begin
    sb.delete();
    m_ptr = '0;
    m_ov  = 1'b0;
  end

  // Reference model of the 4-channel instance; inputs are stable here.
  always @(negedge clk) begin
    if (rst_n) begin
      m_w = -1;
      for (int k = 0; k < 4; k++) begin
        m_j = (int'(m_ptr) + k) % 4;
        if (m_w < 0 && in_valid[m_j]) m_w = m_j;
      end
      m_rdy = (m_w >= 0 && (!m_ov || out_ready)) ? (4'd1 << m_w) : 4'd0;
      checks++;
      if (in_ready !== m_rdy) begin
        errors++;
        $display("FAIL sb_in_ready got %b exp %b", in_ready, m_rdy);
      end
      checks++;
      if (out_valid !== m_ov) begin
        errors++;
        $display("FAIL sb_out_valid got %b exp %b", out_valid, m_ov);
      end
      if (m_ov && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_empty got pop exp word");
        end else begin
          e = sb.pop_front();
          if (out_ch !== e.ch || out_data !== e.data) begin
            errors++;
            $display("FAIL sb_word got ch%0d %h exp ch%0d %h",
                     out_ch, out_data, e.ch, e.data);
          end
        end
      end
      if (m_rdy != 4'd0) begin
        e.ch   = 2'(m_w);
        e.data = in_data[m_w*128 +: 128];
        sb.push_back(e);
        m_ptr = (m_w == 3) ? 2'd0 : 2'(m_w + 1);
        m_ov  = 1'b1;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < 16; i++) in_data[i*32 +: 32] = $urandom;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    v5        = '0;
    or5       = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [127:0] d2;
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0) begin
      errors++;
      $display("FAIL reset_vals got v%b d%h c%0d exp 0", out_valid, out_data, out_ch);
    end
    rand_data();
    in_valid = 4'b0001;
    tick();
    in_valid = 4'hF;
    rst_n    = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0) begin
      errors++;
      $display("FAIL async_reset got v%b r%b exp v0 r0000", out_valid, in_ready);
    end
    tick();
    rand_data();
    d2       = in_data[256 +: 128];
    in_valid = 4'b0100;
    rst_n    = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL post_reset_ready got %b exp 0100", in_ready);
    end
    tick();
    in_valid = '0;
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== d2) begin
      errors++;
      $display("FAIL post_reset_word got v%b c%0d %h exp v1 c2 %h",
               out_valid, out_ch, out_data, d2);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_fairness();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 4'hF;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'(i % 4)) begin
        errors++;
        $display("FAIL fair_%0d got v%b c%0d exp v1 c%0d", i, out_valid, out_ch, i % 4);
      end
    end
    in_valid = '0;
    repeat (2) tick();
  endtask

  task automatic test_backpressure();
    logic [127:0] a5;
    logic [127:0] d1;
    do_reset();
    a5 = {16{8'hA5}};
    in_data[127:0] = a5;
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    tick();
    in_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      #1;
      checks++;
      if (in_ready !== 4'b0 || out_valid !== 1'b1 || out_data !== a5) begin
        errors++;
        $display("FAIL stall_%0d got r%b v%b %h exp r0000 v1 %h",
                 i, in_ready, out_valid, out_data, a5);
      end
      tick();
    end
    d1 = in_data[128 +: 128];
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL release_ready got %b exp 0010", in_ready);
    end
    tick();
    in_valid = '0;
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== d1) begin
      errors++;
      $display("FAIL release_word got v%b c%0d %h exp v1 c1 %h",
               out_valid, out_ch, out_data, d1);
    end
    repeat (2) tick();
  endtask

  task automatic test_bubble();
    logic [127:0] d1;
    do_reset();
    rand_data();
    d1        = in_data[128 +: 128];
    in_valid  = 4'b0010;
    out_ready = 1'b1;
    tick();
    in_valid = '0;
    rand_data();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== d1) begin
      errors++;
      $display("FAIL bubble_word got v%b c%0d exp v1 c1", out_valid, out_ch);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== d1 || out_ch !== 2'd1) begin
        errors++;
        $display("FAIL bubble_hold_%0d got v%b %h exp v0 %h", i, out_valid, out_data, d1);
      end
    end
  endtask

  task automatic test_wrap();
    int exp_ch [3] = '{4, 0, 4};
    do_reset();
    for (int i = 0; i < 20; i++) d5[i*32 +: 32] = $urandom;
    v5  = 5'b00001;
    or5 = 1'b1;
    tick();
    v5 = 5'b10001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ov5 !== 1'b1 || oc5 !== 3'(exp_ch[i]) ||
          od5 !== d5[exp_ch[i]*128 +: 128]) begin
        errors++;
        $display("FAIL wrap_%0d got v%b c%0d exp v1 c%0d", i, ov5, oc5, exp_ch[i]);
      end
    end
    v5 = '0;
    tick();
  endtask

`ifdef HASH_UPD_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 4'b1000;
    repeat (10) begin
      rand_data();
      tick();
    end
    in_valid = '0;
    tick();
    checks++;
    if (gc4[96 +: 32] !== 32'd10 || gc4[0 +: 32] !== 32'd0) begin
      errors++;
      $display("FAIL stats_cnt got %0d/%0d exp 10/0", gc4[96 +: 32], gc4[0 +: 32]);
    end
    in_valid = 4'b1000;
    sc4      = 1'b1;
    tick();
    sc4      = 1'b0;
    in_valid = '0;
    checks++;
    if (gc4[96 +: 32] !== 32'd0) begin
      errors++;
      $display("FAIL stats_clr got %0d exp 0", gc4[96 +: 32]);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_fairness();
    test_backpressure();
    test_bubble();
    test_wrap();
`ifdef HASH_UPD_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
